// File: rtl/calc_pkg.sv
// Shared op codes, FSM states and the inline ALU for the calculator sequencer.
package calc_pkg;

   localparam int CALC_MAXW = 64;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRA = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   typedef struct packed {
      logic [CALC_MAXW-1:0] res;
      logic                 ovf;
   } alu_out_t;

   // Operands arrive sign-extended to CALC_MAXW; the caller keeps the low
   // WIDTH bits, and msb selects the WIDTH-bit sign position for overflow.
   function automatic alu_out_t calc_alu(input logic [2:0]           op,
                                         input logic [CALC_MAXW-1:0] a,
                                         input logic [CALC_MAXW-1:0] b,
                                         input logic [5:0]           sh,
                                         input logic [5:0]           msb);
      alu_out_t o;
      o.res = '0;
      o.ovf = 1'b0;
      case (op)
         OP_ADD: begin
            o.res = a + b;
            o.ovf = (a[msb] == b[msb]) && (o.res[msb] != a[msb]);
         end
         OP_SUB: begin
            o.res = a - b;
            o.ovf = (a[msb] != b[msb]) && (o.res[msb] != a[msb]);
         end
         OP_AND:  o.res = a & b;
         OP_OR:   o.res = a | b;
         OP_XOR:  o.res = a ^ b;
         OP_SLL:  o.res = a << sh;
         OP_SRA:  o.res = $signed(a) >>> sh;
         OP_MUL:  o.res = a * b;
         default: o.res = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/calc_seq_if.sv
// Board-side bundle of the calculator: switches, raw buttons, LEDs and status.
interface calc_seq_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] sw;
   logic             btnl;
   logic             btnc;
   logic             btnr;
   logic             btnd;
   logic             btnu;
   logic             btn_undo;
   logic [WIDTH-1:0] led;
   logic             ovf;
   logic             busy;

   modport master (output sw, btnl, btnc, btnr, btnd, btnu, btn_undo,
                   input  led, ovf, busy);
   modport slave  (input  sw, btnl, btnc, btnr, btnd, btnu, btn_undo,
                   output led, ovf, busy);
endinterface

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, stable-level debouncer (down-counter,
// terminal count at zero) and a one-cycle pulse on the accepted rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_pulse
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [1:0]    r_sync;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // The counter is reloaded whenever the input agrees with the accepted level,
   // so any bounce restarts the full window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync    <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], i_btn};
         r_level_d <= r_level;
         if (r_sync[1] == r_level) begin
            r_cnt <= CW'(DEBOUNCE_CYCLES - 1);
         end else if (r_cnt == '0) begin
            r_level <= r_sync[1];
            r_cnt   <= CW'(DEBOUNCE_CYCLES - 1);
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_pulse = r_level & ~r_level_d;
endmodule

// File: rtl/calc_seq.sv
// Calculator datapath: debounced execute/clear/undo, 3-state execute FSM,
// sticky overflow. Optional undo history under `CALC_UNDO_EN.
//  state  | meaning
//  S_IDLE | waiting for execute / undo
//  S_EXEC | operands latched, ALU result being registered
//  S_WB   | result written to accumulator, old value pushed to history
module calc_seq
   import calc_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HIST_DEPTH      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   calc_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   state_t                  r_state, w_state_nx;
   logic [2:0]              r_op_s1, r_op_s2, r_op;
   logic signed [WIDTH-1:0] r_acc, r_a, r_b, r_res;
   logic                    r_res_ovf, r_ovf;
   logic                    w_exe_pulse, w_clr_pulse, w_undo_go, w_exe_go;
   logic                    w_busy, w_wb_en;
   logic signed [WIDTH-1:0] w_hist_top, w_sw;
   alu_out_t                w_alu;
   logic                    w_unused_alu;

   assign w_sw = bus.sw;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_exe (
      .clk(clk), .rst_n(rst_n), .i_btn(bus.btnd), .o_pulse(w_exe_pulse));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clk(clk), .rst_n(rst_n), .i_btn(bus.btnu), .o_pulse(w_clr_pulse));

   assign w_exe_go = w_exe_pulse & ~w_clr_pulse & ~w_undo_go & (r_state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      if (w_clr_pulse) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_exe_go) w_state_nx = S_EXEC;
            S_EXEC:  w_state_nx = S_WB;
            S_WB:    w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy  = (r_state != S_IDLE);
      w_wb_en = (r_state == S_WB) & ~w_clr_pulse;
   end

   always_comb w_alu = calc_alu(r_op, CALC_MAXW'(r_a), CALC_MAXW'(r_b),
                                6'(r_b[SHW-1:0]), 6'(WIDTH - 1));
   assign w_unused_alu = ^w_alu.res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_s1   <= '0;
         r_op_s2   <= '0;
         r_op      <= OP_ADD;
         r_a       <= '0;
         r_b       <= '0;
         r_res     <= '0;
         r_res_ovf <= 1'b0;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_op_s1 <= {bus.btnl, bus.btnc, bus.btnr};
         r_op_s2 <= r_op_s1;
         if (w_exe_go) begin
            r_op <= r_op_s2;
            r_a  <= r_acc;
            r_b  <= w_sw;
         end
         if (r_state == S_EXEC) begin
            r_res     <= w_alu.res[WIDTH-1:0];
            r_res_ovf <= w_alu.ovf;
         end
         if (w_clr_pulse) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (w_wb_en) begin
            r_acc <= r_res;
            if (r_res_ovf) r_ovf <= 1'b1;
         end else if (w_undo_go) begin
            r_acc <= w_hist_top;
         end
      end
   end

`ifdef CALC_UNDO_EN
   localparam int HW = $clog2(HIST_DEPTH);

   logic                    w_undo_pulse;
   logic signed [WIDTH-1:0] r_hist [HIST_DEPTH];
   logic [HW-1:0]           r_hptr;
   logic [HW:0]             r_hcnt;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_undo (
      .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_undo), .o_pulse(w_undo_pulse));

   assign w_undo_go  = w_undo_pulse & ~w_clr_pulse & (r_state == S_IDLE) & (r_hcnt != '0);
   assign w_hist_top = r_hist[r_hptr - 1'b1];

   // Circular stack: r_hptr is the next write slot; a full push overwrites the oldest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
         r_hptr <= '0;
         r_hcnt <= '0;
      end else if (w_clr_pulse) begin
         r_hptr <= '0;
         r_hcnt <= '0;
      end else if (w_wb_en) begin
         r_hist[r_hptr] <= r_acc;
         r_hptr         <= r_hptr + 1'b1;
         if (r_hcnt != (HW + 1)'(HIST_DEPTH)) r_hcnt <= r_hcnt + 1'b1;
      end else if (w_undo_go) begin
         r_hptr <= r_hptr - 1'b1;
         r_hcnt <= r_hcnt - 1'b1;
      end
   end
`else
   localparam int hist_depth_unused = HIST_DEPTH;
   logic w_unused_undo;
   assign w_unused_undo = bus.btn_undo;
   assign w_undo_go     = 1'b0;
   assign w_hist_top    = '0;
`endif

   assign bus.led  = r_acc;
   assign bus.ovf  = r_ovf;
   assign bus.busy = w_busy;
endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with WIDTH=16, DEBOUNCE_CYCLES=4, HIST_DEPTH=2.
module tb_calc_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   calc_seq_if #(.WIDTH(16)) bus ();

   calc_seq #(.WIDTH(16), .DEBOUNCE_CYCLES(4), .HIST_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   // Holds the chosen buttons for 'hold' cycles, then idles long enough for the
   // release to debounce. Reports busy rising edges and when led first changed.
   task automatic press(input logic d, input logic u, input logic un, input int hold,
                        output int n_rise, output int t_rise, output int t_led);
      logic        prev_busy;
      logic [15:0] led0;
      led0 = bus.led;
      prev_busy = bus.busy;
      n_rise = 0; t_rise = -1; t_led = -1;
      bus.btnd = d; bus.btnu = u; bus.btn_undo = un;
      for (int i = 0; i < hold + 14; i++) begin
         @(negedge clk);
         if (i == hold - 1) begin
            bus.btnd = 1'b0; bus.btnu = 1'b0; bus.btn_undo = 1'b0;
         end
         if (bus.busy && !prev_busy) begin
            n_rise++;
            if (t_rise < 0) t_rise = i;
         end
         prev_busy = bus.busy;
         if (t_led < 0 && bus.led !== led0) t_led = i;
      end
   endtask

   task automatic set_op(input logic [2:0] op, input logic [15:0] sw);
      {bus.btnl, bus.btnc, bus.btnr} = op;
      bus.sw = sw;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      int  nr, tr, tl;
      bit  found;
      rst_n = 1'b0;
      bus.sw = '0; bus.btnl = 0; bus.btnc = 0; bus.btnr = 0;
      bus.btnd = 0; bus.btnu = 0; bus.btn_undo = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.led !== 16'h0 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_init led=%h ovf=%b busy=%b want 0000/0/0", bus.led, bus.ovf, bus.busy);
      end
      rst_n = 1'b1;
      set_op(3'b000, 16'h0005);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0005) begin
         errors++; $display("FAIL reset_pre_add led=%h want 0005", bus.led);
      end
      bus.sw = 16'h0003;
      bus.btnd = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.busy) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL reset_reach_exec busy=%b want 1 within 20 cycles", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.led !== 16'h0 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_async led=%h ovf=%b busy=%b want 0000/0/0", bus.led, bus.ovf, bus.busy);
      end
      bus.btnd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (bus.led !== 16'h0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_after led=%h busy=%b want 0000/0", bus.led, bus.busy);
      end
   endtask

   task automatic test_add_seq();
      int nr, tr, tl;
      set_op(3'b000, 16'h0005);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0005 || nr !== 1) begin
         errors++; $display("FAIL add_first led=%h rises=%0d want 0005/1", bus.led, nr);
      end
      checks++;
      if (tl - tr !== 2) begin
         errors++; $display("FAIL add_first_latency got %0d want 2 cycles after busy rise", tl - tr);
      end
      set_op(3'b000, 16'h0003);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0008 || nr !== 1 || tl - tr !== 2) begin
         errors++; $display("FAIL add_second led=%h rises=%0d lat=%0d want 0008/1/2", bus.led, nr, tl - tr);
      end
   endtask

   task automatic test_bounce();
      int nr, tr, tl;
      bit rose;
      set_op(3'b001, 16'h0002);
      rose = 0;
      for (int i = 0; i < 21; i++) begin
         bus.btnd = (i < 2) || (i >= 4 && i < 6);
         @(negedge clk);
         if (bus.busy) rose = 1;
      end
      checks++;
      if (rose || bus.led !== 16'h0008) begin
         errors++; $display("FAIL bounce_nopulse busy_seen=%b led=%h want 0/0008", rose, bus.led);
      end
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0006 || nr !== 1) begin
         errors++; $display("FAIL bounce_stable_sub led=%h rises=%0d want 0006/1", bus.led, nr);
      end
   endtask

   task automatic test_ovf();
      int nr, tr, tl;
      press(0, 1, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0 || bus.ovf !== 1'b0 || nr !== 0) begin
         errors++; $display("FAIL ovf_clear0 led=%h ovf=%b rises=%0d want 0000/0/0", bus.led, bus.ovf, nr);
      end
      set_op(3'b000, 16'h7FFF);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h7FFF || bus.ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_load led=%h ovf=%b want 7fff/0", bus.led, bus.ovf);
      end
      set_op(3'b000, 16'h0001);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h8000 || bus.ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_add led=%h ovf=%b want 8000/1", bus.led, bus.ovf);
      end
      set_op(3'b010, 16'hFFFF);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h8000 || bus.ovf !== 1'b1 || nr !== 1) begin
         errors++; $display("FAIL ovf_sticky_and led=%h ovf=%b rises=%0d want 8000/1/1", bus.led, bus.ovf, nr);
      end
      press(0, 1, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0 || bus.ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clear1 led=%h ovf=%b want 0000/0", bus.led, bus.ovf);
      end
      set_op(3'b001, 16'h8000);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h8000 || bus.ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_sub led=%h ovf=%b want 8000/1", bus.led, bus.ovf);
      end
      press(0, 1, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0 || bus.ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clear2 led=%h ovf=%b want 0000/0", bus.led, bus.ovf);
      end
   endtask

   task automatic test_shift_mul();
      int nr, tr, tl;
      set_op(3'b000, 16'h8000);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h8000 || bus.ovf !== 1'b0) begin
         errors++; $display("FAIL sm_load led=%h ovf=%b want 8000/0", bus.led, bus.ovf);
      end
      set_op(3'b110, 16'h0004);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'hF800) begin
         errors++; $display("FAIL sm_sra led=%h want f800", bus.led);
      end
      set_op(3'b111, 16'hFFFF);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0800) begin
         errors++; $display("FAIL sm_mul led=%h want 0800", bus.led);
      end
      set_op(3'b101, 16'h0013);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h4000) begin
         errors++; $display("FAIL sm_sll led=%h want 4000", bus.led);
      end
      set_op(3'b100, 16'h4321);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0321 || bus.ovf !== 1'b0) begin
         errors++; $display("FAIL sm_xor led=%h ovf=%b want 0321/0", bus.led, bus.ovf);
      end
      set_op(3'b011, 16'h1004);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h1325) begin
         errors++; $display("FAIL sm_or led=%h want 1325", bus.led);
      end
   endtask

   task automatic test_clear_exec();
      int nr, tr, tl;
      set_op(3'b000, 16'h0001);
      press(1, 1, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0 || bus.ovf !== 1'b0 || nr !== 0) begin
         errors++; $display("FAIL clear_exec led=%h ovf=%b rises=%0d want 0000/0/0", bus.led, bus.ovf, nr);
      end
   endtask

   task automatic test_undo();
      int nr, tr, tl;
      set_op(3'b000, 16'h0001);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0001) begin
         errors++; $display("FAIL undo_exec1 led=%h want 0001", bus.led);
      end
`ifdef CALC_UNDO_EN
      press(1, 0, 0, 10, nr, tr, tl);
      press(1, 0, 0, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0003) begin
         errors++; $display("FAIL undo_exec3 led=%h want 0003", bus.led);
      end
      press(0, 0, 1, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0002 || nr !== 0) begin
         errors++; $display("FAIL undo_pop1 led=%h rises=%0d want 0002/0", bus.led, nr);
      end
      press(0, 0, 1, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0001) begin
         errors++; $display("FAIL undo_pop2 led=%h want 0001", bus.led);
      end
      press(0, 0, 1, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0001) begin
         errors++; $display("FAIL undo_empty led=%h want 0001", bus.led);
      end
      set_op(3'b000, 16'h0004);
      press(1, 0, 0, 10, nr, tr, tl);
      press(0, 0, 1, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0001) begin
         errors++; $display("FAIL undo_after_refill led=%h want 0001", bus.led);
      end
`else
      press(0, 0, 1, 10, nr, tr, tl);
      checks++;
      if (bus.led !== 16'h0001 || nr !== 0) begin
         errors++; $display("FAIL undo_disabled led=%h rises=%0d want 0001/0", bus.led, nr);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_add_seq();
      test_bounce();
      test_ovf();
      test_shift_mul();
      test_clear_exec();
      test_undo();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Parametrised, fully synchronous successor of the board calculator: a WIDTH-bit signed accumulator updated by an internal ALU on a debounced "execute" button press.
- Raw buttons are synchronised, debounced and edge-detected inside the block, on a single clock with no button-driven clocking.
- Adds a sticky signed-overflow flag, a small execute FSM and an optional undo history.
- Sits between the board I/O (sw, buttons, led) and nothing else; it is the top-level datapath of the calculator.

Parameters:
- WIDTH, 16, accumulator, switch and LED width (>=4).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button level is accepted (>=1).
- HIST_DEPTH, 8, undo history entries (power of two, >=2; used only with CALC_UNDO_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  WIDTH  operand 2, signed.
- btnl  in  1  op select bit 2, raw.
- btnc  in  1  op select bit 1, raw.
- btnr  in  1  op select bit 0, raw.
- btnd  in  1  execute, raw, debounced.
- btnu  in  1  clear, raw, debounced.
- btn_undo  in  1  undo, raw, debounced; ignored unless CALC_UNDO_EN.
- led  out  WIDTH  displayed accumulator.
- ovf  out  1  sticky signed overflow.
- busy  out  1  high while FSM not IDLE.

Behaviour:
- Reset (rst_n low, async): accumulator=0, led=0, ovf=0, busy=0, FSM=IDLE, debounce counters=0, debounced levels=0, history empty.
- Input conditioning: every button passes a 2-FF synchroniser. btnd/btnu/btn_undo then pass a debouncer: the accepted level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. A one-cycle pulse is generated on the rising edge of the accepted level.
- Op select {btnl,btnc,btnr}, synchronised only, is sampled in the cycle of the execute pulse:
  - 000 ADD
  - 001 SUB (acc-sw)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL by sw[$clog2(WIDTH)-1:0]
  - 110 SRA by the same field
  - 111 MUL, low WIDTH bits of the signed product
- FSM:
  - IDLE -> EXEC on execute pulse: latch op, acc, sw.
  - EXEC -> WB: compute result and overflow into a register.
  - WB -> IDLE: accumulator<=result, led<=result, push old acc to history.
  - Update is visible 2 cycles after the pulse cycle. busy=1 in EXEC and WB.
- Execute pulses arriving while busy are dropped, not queued.
- ovf: set in WB when an ADD/SUB signed result overflows (operand signs rule). It is sticky and cleared only by clear or reset. Other ops never set it.
- Clear pulse, any state: next cycle accumulator=0, led=0, ovf=0, FSM=IDLE. An in-flight EXEC/WB is aborted with no write, and history is emptied.
- Priority in the same cycle: clear > undo > execute.
- Arithmetic wraps modulo 2^WIDTH. A shift amount >= WIDTH cannot occur by construction.

Optional Feature:
- Macro: CALC_UNDO_EN.
- Defined:
  - HIST_DEPTH-entry circular stack of previous accumulator values.
  - Each WB pushes the pre-update accumulator. When full, the oldest entry is overwritten and the count saturates at HIST_DEPTH.
  - An undo pulse in IDLE with non-empty history pops: next cycle accumulator=led=popped value, ovf unchanged.
  - Undo when empty, or while busy, is ignored.
- Undefined: no history storage, and btn_undo is unused (tie-off tolerated).

Decomposition:
- Package calc_pkg holds:
  - op-code localparams (OP_ADD..OP_MUL, 3 bits)
  - FSM state enum (S_IDLE, S_EXEC, S_WB)
  - a function computing the result and overflow for an op, two WIDTH operands and a shift amount.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES): synchroniser, debouncer and rising-edge pulse for one button; instantiated three times.
- The ALU stays inline via the package function.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=16):
- Reset mid-EXEC (rst_n low for 1 cycle) -> led=0, ovf=0, busy=0 immediately (async).
- op=000, sw=0x0005, btnd held 10 cycles, then sw=0x0003 and press again -> led=0x0005, then 0x0008. Each update lands 2 cycles after its pulse, exactly once per press.
- btnd bouncing 1-0-1 with 2-cycle gaps -> no pulse. Then a stable press -> one pulse and a single update.
- acc=0x7FFF, op=000, sw=0x0001 -> led=0x8000, ovf=1. Then op=010 with sw=0xFFFF -> ovf stays 1. Then btnu -> led=0, ovf=0.
- acc=0x8000, op=110, sw=0x0004 -> led=0xF800. op=111, sw=0xFFFF -> led=0x0800.
- CALC_UNDO_EN, HIST_DEPTH=2: three executes give 1, 2, 3; undo x3 -> led=2, then 1, then third undo ignored (led=1). Clear and execute in the same cycle -> led=0, no write.
